// File: rtl/pong_court_pkg.sv
// pong_court_pkg: constants shared between the pong controller and the court
// datapath.
//   MODE_*         encodings of the 2-bit court mode select s
//   DEF_*          default court width, score width and winning score
package pong_court_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SCORE_W   = 4;
    localparam int DEF_WIN_SCORE = 9;

endpackage

// File: rtl/pong_court_score_counter.sv
// pong_score_counter: saturating up-counter for one player's score.
//   clk, ireset  clock, synchronous active-high reset
//   inc          one-cycle increment request
//   en           increment enable (low freezes the count)
//   max          saturation value
//   count        current count
//   at_max       the count after this edge equals max. It is computed from the
//                next value, so the owner can register it on the same edge.
module pong_score_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         ireset,
    input  logic         inc,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (inc && en && (count != max)) begin
            count_next = count + 1'b1;
        end
    end

    assign at_max = (count_next == max);

    always_ff @(posedge clk) begin
        if (ireset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/pong_court.sv
// pong_court: ball-position shift register and score keeping for pong.
//   clk, ireset   clock, synchronous active-high reset
//   s             mode: hold / shift right / shift left / clear
//   lsi, rsi      serial inputs for shift left / shift right
//   lct, rct      one-cycle pulses that score a point for left / right
//   court         ball register, bit WIDTH-1 is the leftmost LED
//   qleft/qright  end-of-court bits, taken straight from the register
//   lscore/rscore player scores
//   game_over     sticky flag, set on the edge a score reaches WIN_SCORE
module pong_court
    import pong_court_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int WIN_SCORE = DEF_WIN_SCORE
) (
    input  logic               clk,
    input  logic               ireset,
    input  logic [1:0]         s,
    input  logic               lsi,
    input  logic               rsi,
    input  logic               lct,
    input  logic               rct,
    output logic [WIDTH-1:0]   court,
    output logic               qleft,
    output logic               qright,
    output logic [SCORE_W-1:0] lscore,
    output logic [SCORE_W-1:0] rscore,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] WIN_MAX = SCORE_W'(WIN_SCORE);

    logic at_max_l;
    logic at_max_r;

    // Court shift register. An unknown mode falls into the hold arm.
    always_ff @(posedge clk) begin
        if (ireset) begin
            court <= '0;
        end else begin
            case (s)
                MODE_SHR: court <= {rsi, court[WIDTH-1:1]};
                MODE_SHL: court <= {court[WIDTH-2:0], lsi};
                MODE_CLR: court <= '0;
                default:  court <= court;
            endcase
        end
    end

    assign qleft  = court[WIDTH-1];
    assign qright = court[0];

    // Scores freeze once the game is over; they never look at s.
    pong_score_counter #(.W(SCORE_W)) u_lscore (
        .clk    (clk),
        .ireset (ireset),
        .inc    (lct),
        .en     (~game_over),
        .max    (WIN_MAX),
        .count  (lscore),
        .at_max (at_max_l)
    );

    pong_score_counter #(.W(SCORE_W)) u_rscore (
        .clk    (clk),
        .ireset (ireset),
        .inc    (rct),
        .en     (~game_over),
        .max    (WIN_MAX),
        .count  (rscore),
        .at_max (at_max_r)
    );

    // at_max_* look at next-cycle scores, so game_over rises with the
    // winning point and then stays up until reset.
    always_ff @(posedge clk) begin
        if (ireset) begin
            game_over <= 1'b0;
        end else if (at_max_l || at_max_r) begin
            game_over <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pong_court.sv
module tb_pong_court;

    logic       clk = 1'b0;
    logic       ireset;
    logic [1:0] s;
    logic       lsi, rsi, lct, rct;
    logic [7:0] court;
    logic       qleft, qright;
    logic [3:0] lscore, rscore;
    logic       game_over;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural reference: court as a plain integer, scores as integers.
    int m_court;
    int m_l, m_r;
    bit m_go;

    pong_court #(.WIDTH(8), .SCORE_W(4), .WIN_SCORE(9)) dut (
        .clk       (clk),
        .ireset    (ireset),
        .s         (s),
        .lsi       (lsi),
        .rsi       (rsi),
        .lct       (lct),
        .rct       (rct),
        .court     (court),
        .qleft     (qleft),
        .qright    (qright),
        .lscore    (lscore),
        .rscore    (rscore),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic drive(input bit rst, input logic [1:0] mode, input bit l_in,
                         input bit r_in, input bit lc, input bit rc);
        ireset = rst; s = mode; lsi = l_in; rsi = r_in; lct = lc; rct = rc;
        @(posedge clk);
        if (rst) begin
            m_court = 0; m_l = 0; m_r = 0; m_go = 0;
        end else begin
            if (mode == 2'd1)      m_court = (m_court / 2) + (r_in ? 128 : 0);
            else if (mode == 2'd2) m_court = ((m_court * 2) % 256) + (l_in ? 1 : 0);
            else if (mode == 2'd3) m_court = 0;
            if (!m_go) begin
                if (lc && m_l < 9) m_l++;
                if (rc && m_r < 9) m_r++;
                m_go = (m_l == 9) || (m_r == 9);
            end
        end
        #1;
        ireset = 1'b0; s = 2'd0; lsi = 0; rsi = 0; lct = 0; rct = 0;
    endtask

    task automatic test_reset();
        drive(1, 2'd0, 0, 0, 0, 0);
        drive(1, 2'd0, 0, 0, 0, 0);
        tests_run++;
        if ({court, qleft, qright, lscore, rscore, game_over} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset: got court=%b l=%0d r=%0d go=%b, want all zero",
                     court, lscore, rscore, game_over);
        end
    endtask

    task automatic test_shift();
        // Walk the ball left across the court.
        drive(0, 2'd2, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (court !== 8'(1 << i) || qleft !== (i == 7) || qright !== (i == 0)) begin
                tests_failed++;
                $display("FAIL shl step %0d: court=%b ql=%b qr=%b, want %b", i, court,
                         qleft, qright, 8'(1 << i));
            end
            if (i < 7) drive(0, 2'd2, 0, 0, 0, 0);
        end
        // And back to the right.
        for (int i = 6; i >= 0; i--) begin
            drive(0, 2'd1, 0, 0, 0, 0);
            tests_run++;
            if (court !== 8'(1 << i) || qright !== (i == 0) || qleft !== 1'b0) begin
                tests_failed++;
                $display("FAIL shr to bit %0d: court=%b qr=%b, want %b", i, court, qright,
                         8'(1 << i));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 1, 1, 0, 0);
            tests_run++;
            if (court !== 8'b0000_0001) begin
                tests_failed++;
                $display("FAIL hold %0d: court=%b, want 00000001", i, court);
            end
        end
    endtask

    task automatic test_clear();
        drive(0, 2'd3, 0, 0, 0, 0);
        drive(0, 2'd2, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 2'd2, 0, 0, 0, 0);
        tests_run++;
        if (court !== 8'b0001_0000) begin
            tests_failed++;
            $display("FAIL clear setup: court=%b, want 00010000", court);
        end
        drive(0, 2'd3, 1, 1, 0, 0);
        tests_run++;
        if (court !== 8'd0) begin
            tests_failed++;
            $display("FAIL clear: court=%b, want 00000000", court);
        end
        drive(0, 2'd1, 0, 1, 0, 0);
        tests_run++;
        if (court !== 8'b1000_0000 || qleft !== 1'b1) begin
            tests_failed++;
            $display("FAIL shr serial in: court=%b ql=%b, want 10000000 ql=1", court, qleft);
        end
    endtask

    task automatic test_win_left();
        drive(1, 2'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            drive(0, 2'd0, 0, 0, 1, 0);
            tests_run++;
            if (lscore !== 4'(i) || game_over !== (i == 9)) begin
                tests_failed++;
                $display("FAIL lct %0d: lscore=%0d go=%b, want %0d go=%b", i, lscore,
                         game_over, i, (i == 9));
            end
        end
        drive(0, 2'd0, 0, 0, 1, 1);
        tests_run++;
        if (lscore !== 4'd9 || rscore !== 4'd0 || game_over !== 1'b1) begin
            tests_failed++;
            $display("FAIL after game over: l=%0d r=%0d go=%b, want 9 0 1", lscore, rscore,
                     game_over);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 2'd0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 2'd0, 0, 0, 0, 1);
        drive(0, 2'd0, 0, 0, 1, 1);
        tests_run++;
        if (lscore !== 4'd4 || rscore !== 4'd5 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL both 3/4: l=%0d r=%0d go=%b, want 4 5 0", lscore, rscore, game_over);
        end
        drive(1, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 2'd0, 0, 0, 1, 1);
        tests_run++;
        if (lscore !== 4'd8 || rscore !== 4'd8 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL both 8/8: l=%0d r=%0d go=%b, want 8 8 0", lscore, rscore, game_over);
        end
        drive(0, 2'd0, 0, 0, 1, 1);
        tests_run++;
        if (lscore !== 4'd9 || rscore !== 4'd9 || game_over !== 1'b1) begin
            tests_failed++;
            $display("FAIL both 9/9: l=%0d r=%0d go=%b, want 9 9 1", lscore, rscore, game_over);
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 2'd0, 0, 0, 0, 0);
        drive(0, 2'd2, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 2'd2, 0, 0, 1, 0);
        tests_run++;
        if (court !== 8'b0010_0000 || lscore !== 4'd5) begin
            tests_failed++;
            $display("FAIL mid setup: court=%b l=%0d, want 00100000 5", court, lscore);
        end
        drive(1, 2'd2, 1, 0, 1, 0);
        tests_run++;
        if ({court, lscore, rscore, game_over} !== 17'd0) begin
            tests_failed++;
            $display("FAIL mid reset: court=%b l=%0d r=%0d go=%b, want all zero", court,
                     lscore, rscore, game_over);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            tests_run++;
            if (court !== 8'(m_court) || qleft !== 1'(m_court / 128)
                || qright !== 1'(m_court % 2) || lscore !== 4'(m_l)
                || rscore !== 4'(m_r) || game_over !== m_go) begin
                tests_failed++;
                $display("FAIL random %0d: court=%b l=%0d r=%0d go=%b, want %b %0d %0d %b",
                         n, court, lscore, rscore, game_over, 8'(m_court), m_l, m_r, m_go);
            end
        end
    endtask

    initial begin
        ireset = 1'b1; s = 2'd0; lsi = 0; rsi = 0; lct = 0; rct = 0;
        m_court = 0; m_l = 0; m_r = 0; m_go = 0;
        test_reset();
        test_shift();
        test_clear();
        test_win_left();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
